// File: rtl/control_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Contents: state encodings (also visible on the estado debug port), opcode
// constants, ALUOp / ALUSrcB / PCSource encodings, and helpers that decide
// opcode legality and instruction retirement.
package control_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // addi is only a legal opcode when the build enables it.
    function automatic logic opcode_legal(input logic [5:0] op, input logic addi_en);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opcode_legal = 1'b1;
            OP_ADDI:                              opcode_legal = addi_en;
            default:                              opcode_legal = 1'b0;
        endcase
    endfunction

    // True on the final cycle of an instruction; a store only finishes once
    // memory acknowledges it.
    function automatic logic retires(input state_t s, input logic mem_ready);
        case (s)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retires = 1'b1;
            S_MEMWR:                                      retires = mem_ready;
            default:                                      retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low clear
//   en     in   increment this cycle
//   count  out  CNT_W-bit count, wraps modulo 2^CNT_W
module instr_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS datapath. Decodes the opcode,
// sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives the datapath enables
// and mux selects plus ALUOp for ALU_Control, honours a memory-ready
// handshake and counts retired instructions.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   opcode[5:0]            instruction[31:26], used in DECODE and MEMADR
//   mem_ready              memory access completes this cycle
//   PCWrite .. ALUSrcA     single-bit datapath controls
//   ALUSrcB[1:0]           00 B, 01 4, 10 sign-ext imm, 11 imm<<2
//   PCSource[1:0]          00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp[1:0]             00 add, 01 subtract, 10 use funct
//   estado[3:0]            current state code (debug)
//   illegal_op             high during a DECODE cycle holding an undefined opcode
//   instr_count[CNT_W-1:0] retired instructions
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter bit ADDI_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [3:0]       estado,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state <= S_EXEC;
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= ADDI_EN ? S_ADDIEX : S_FETCH;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_ADDIEX: state <= S_ADDIWB;
                S_ADDIWB: state <= S_FETCH;
                // Codes 13-15 are unreachable; recover through RESET.
                default:  state <= S_RESET;
            endcase
        end
    end

    // Moore decode; only IRWrite/PCWrite in FETCH and illegal_op in DECODE
    // also look at an input, so a stalled fetch never writes PC or IR.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = !opcode_legal(opcode, ADDI_EN);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign estado = state;

    // Reset clears the counter with priority, so an instruction cut short by
    // rst_n is never counted.
    instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retires(state, mem_ready)),
        .count (instr_count)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc, aluop;
        logic [3:0] st;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // DUT A: default build (32-bit counter, addi legal)
    logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_ill;
    logic [1:0]  a_srcb, a_pcsrc, a_aluop;
    logic [3:0]  a_st;
    logic [31:0] a_cnt;
    // DUT B: 4-bit counter, addi illegal
    logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_ill;
    logic [1:0]  b_srcb, b_pcsrc, b_aluop;
    logic [3:0]  b_st;
    logic [3:0]  b_cnt;

    multicycle_control_unit #(.CNT_W(32), .ADDI_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
        .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
        .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .PCSource(a_pcsrc),
        .ALUOp(a_aluop), .estado(a_st), .illegal_op(a_ill), .instr_count(a_cnt)
    );

    multicycle_control_unit #(.CNT_W(4), .ADDI_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
        .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
        .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .PCSource(b_pcsrc),
        .ALUOp(b_aluop), .estado(b_st), .illegal_op(b_ill), .instr_count(b_cnt)
    );

    ctl_t a_act, b_act;
    assign a_act = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca,
                    a_srcb, a_pcsrc, a_aluop, a_st, a_ill};
    assign b_act = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca,
                    b_srcb, b_pcsrc, b_aluop, b_st, b_ill};

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [5:0] op, input bit addi);
        return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
               (op == 6'd2) || (addi && op == 6'd8);
    endfunction

    // Step codes: 0 reset, 1 fetch, 2 decode, 3 mem address, 4 mem read,
    // 5 load writeback, 6 mem write, 7 R execute, 8 R writeback, 9 branch,
    // 10 jump, 11 addi execute, 12 addi writeback.
    function automatic int model_next(input int s, input bit mr, input logic [5:0] op, input bit addi);
        case (s)
            0: return 1;
            1: return mr ? 2 : 1;
            2: begin
                if (!legal(op, addi)) return 1;
                if (op == 6'd0) return 7;
                if (op == 6'd35 || op == 6'd43) return 3;
                if (op == 6'd4) return 9;
                if (op == 6'd2) return 10;
                return 11;
            end
            3: return (op == 6'd35) ? 4 : 6;
            4: return mr ? 5 : 4;
            6: return mr ? 1 : 6;
            7: return 8;
            11: return 12;
            default: return 1;
        endcase
    endfunction

    function automatic bit model_retire(input int s, input bit mr);
        return (s == 5) || (s == 8) || (s == 9) || (s == 10) || (s == 12) || (s == 6 && mr);
    endfunction

    function automatic ctl_t model_out(input int s, input bit mr, input logic [5:0] op, input bit addi);
        ctl_t o;
        o = '0;
        o.st = 4'(s);
        case (s)
            1:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            2:  begin o.srcb = 2'b11; o.ill = !legal(op, addi); end
            3, 11: begin o.srca = 1; o.srcb = 2'b10; end
            4:  begin o.mrd = 1; o.iord = 1; end
            5:  begin o.rw = 1; o.m2r = 1; end
            6:  begin o.mwr = 1; o.iord = 1; end
            7:  begin o.srca = 1; o.aluop = 2'b10; end
            8:  begin o.rw = 1; o.rdst = 1; end
            9:  begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
            10: begin o.pcw = 1; o.pcsrc = 2'b10; end
            12: begin o.rw = 1; end
            default: ;
        endcase
        return o;
    endfunction

    int          ma_state = 0, mb_state = 0;
    int unsigned ma_cnt = 0, mb_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ma_state <= 0; mb_state <= 0; ma_cnt <= 0; mb_cnt <= 0;
        end else begin
            ma_cnt   <= ma_cnt + (model_retire(ma_state, mem_ready) ? 1 : 0);
            mb_cnt   <= (mb_cnt + (model_retire(mb_state, mem_ready) ? 1 : 0)) % 16;
            ma_state <= model_next(ma_state, mem_ready, opcode, 1'b1);
            mb_state <= model_next(mb_state, mem_ready, opcode, 1'b0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        ctl_t ea, eb;
        ea = model_out(ma_state, mem_ready, opcode, 1'b1);
        eb = model_out(mb_state, mem_ready, opcode, 1'b0);
        n_chk++;
        if (a_act !== ea) begin
            n_fail++;
            $display("FAIL model_ctl_a t=%0t got %h expected %h", $time, a_act, ea);
        end
        n_chk++;
        if (b_act !== eb) begin
            n_fail++;
            $display("FAIL model_ctl_b t=%0t got %h expected %h", $time, b_act, eb);
        end
        n_chk++;
        if (a_cnt !== ma_cnt) begin
            n_fail++;
            $display("FAIL model_cnt_a t=%0t got %0d expected %0d", $time, a_cnt, ma_cnt);
        end
        n_chk++;
        if (b_cnt !== 4'(mb_cnt)) begin
            n_fail++;
            $display("FAIL model_cnt_b t=%0t got %0d expected %0d", $time, b_cnt, mb_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then sample mid-cycle.
    task automatic step(input bit rn, input bit mr, input logic [5:0] op, input int exp_st);
        @(posedge clk);
        #1;
        rst_n = rn; mem_ready = mr; opcode = op;
        @(negedge clk);
        chk("estado_a", 32'(a_st), 32'(exp_st));
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

    initial begin
        // Reset and R-type: 0,1,2,7,8,1
        step(0, 1, R, 0);
        chk("reset_outs", 32'(a_act), 32'd0);
        chk("reset_cnt", a_cnt, 0);
        step(1, 1, R, 0);
        step(1, 1, R, 1);
        step(1, 1, R, 2);
        step(1, 1, R, 7);
        chk("exec_aluop", 32'(a_aluop), 32'd2);
        step(1, 1, R, 8);
        chk("aluwb_rw_rdst", {a_rw, a_rdst}, 2'b11);
        step(1, 1, R, 1);
        chk("r_cnt", a_cnt, 1);

        // lw with two wait cycles: 2,3,4,4,4,5,1
        step(1, 1, LW, 2);
        step(1, 1, LW, 3);
        step(1, 0, LW, 4);
        chk("memrd_read", {a_mrd, a_iord, a_rw}, 3'b110);
        step(1, 0, LW, 4);
        chk("memrd_hold", 32'(a_mrd), 1);
        step(1, 1, LW, 4);
        step(1, 1, LW, 5);
        chk("memwb_rw_m2r", {a_rw, a_m2r, a_rdst}, 3'b110);
        chk("memwb_cnt", a_cnt, 1);
        step(1, 1, R, 1);
        chk("lw_cnt", a_cnt, 2);

        // sw, stalled fetch, beq
        step(1, 1, SW, 2);
        step(1, 1, SW, 3);
        chk("memadr_nowrite", 32'(a_mwr), 0);
        step(1, 1, SW, 6);
        chk("memwr_write", 32'(a_mwr), 1);
        step(1, 0, BEQ, 1);
        chk("fetch_stall_ir_pc", {a_irw, a_pcw, a_mrd}, 3'b001);
        chk("sw_cnt", a_cnt, 3);
        step(1, 0, BEQ, 1);
        step(1, 1, BEQ, 1);
        chk("fetch_go_ir_pc", {a_irw, a_pcw}, 2'b11);
        step(1, 1, BEQ, 2);
        step(1, 1, BEQ, 9);
        chk("branch_ctl", {a_aluop, a_pcwc, a_pcsrc, a_mwr}, 6'b01_1_01_0);
        step(1, 1, R, 1);
        chk("beq_cnt", a_cnt, 4);

        // Illegal opcode
        step(1, 1, 6'b111111, 2);
        chk("illegal_a", 32'(a_ill), 1);
        chk("illegal_b", 32'(b_ill), 1);
        step(1, 1, R, 1);
        chk("illegal_drop", 32'(a_ill), 0);
        chk("illegal_cnt", a_cnt, 4);

        // addi: legal on A (2,11,12,1), illegal on B (2,1)
        step(1, 1, ADDI, 2);
        chk("addi_legal_a", 32'(a_ill), 0);
        chk("addi_illegal_b", 32'(b_ill), 1);
        step(1, 1, ADDI, 11);
        chk("addi_b_fetch", 32'(b_st), 1);
        chk("addi_b_cnt", 32'(b_cnt), 4);
        step(1, 1, J, 12);
        chk("addiwb_rw", {a_rw, a_rdst, a_m2r}, 3'b100);
        step(1, 1, SW, 1);
        chk("addi_cnt", a_cnt, 5);
        chk("b_jump", 32'(b_st), 10);

        // Reset during a store wait
        step(1, 1, SW, 2);
        step(1, 1, SW, 3);
        step(1, 0, SW, 6);
        step(1, 0, SW, 6);
        chk("memwr_wait_write", 32'(a_mwr), 1);
        step(0, 0, SW, 6);
        step(1, 1, R, 0);
        chk("rst_mwr_drop", 32'(a_mwr), 0);
        chk("rst_cnt_a", a_cnt, 0);
        chk("rst_st_b", 32'(b_st), 0);
        chk("rst_cnt_b", 32'(b_cnt), 0);
        step(1, 1, R, 1);

        // 16 jumps: B's 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            step(1, 1, J, 2);
            step(1, 1, J, 10);
            chk("jump_ctl_a", {a_pcw, a_pcsrc}, 3'b110);
            chk("jump_ctl_b", {b_pcw, b_pcsrc}, 3'b110);
            step(1, 1, J, 1);
            chk("jump_cnt_a", a_cnt, 32'(i + 1));
            chk("jump_cnt_b", 32'(b_cnt), 32'((i + 1) % 16));
        end
        chk("wrap_cnt_a", a_cnt, 16);
        chk("wrap_cnt_b", 32'(b_cnt), 0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM of the multicycle MIPS datapath; sits directly upstream of ALU_Control.
- Decodes opcode[5:0] from the instruction register and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives every datapath enable and mux select, plus the 2-bit ALUOp consumed by ALU_Control.
- Supports a memory-ready handshake (wait states) and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- ADDI_EN, 1, when 1 opcode 001000 (addi) is legal; when 0 it is treated as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instruction[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  2  00 add, 01 subtract, 10 use funct; goes to ALU_Control.
- estado  out  4  current state code, for debug.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- One clock, clk. Reset is synchronous and active-low, rst_n. While rst_n=0 at a rising edge: state<=RESET, instr_count<=0. In RESET all outputs are 0 and ALUOp=00.
- Moore outputs, decoded combinationally from the state register.
- State codes: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- RESET -> FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, IRWrite=mem_ready, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; PC and IR are not written during the wait.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 with ADDI_EN=1 -> ADDIEX
  - otherwise -> FETCH with illegal_op=1 for exactly that cycle; no counter increment.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1. Holds while mem_ready=0, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds while mem_ready=0, then -> FETCH.
  - MemWrite stays asserted throughout the wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- instr_count increments by 1 on the last cycle of each instruction: MEMWB, MEMWR with mem_ready=1, ALUWB, BRANCH, JUMP, ADDIWB. Wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.
- rst_n=0 in any state, including a wait, returns to RESET on the next edge and drops all strobes. The interrupted instruction is not counted.
- Unused state codes 13-15 -> RESET.

Decomposition:
- control_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - ALUSrcB and PCSource encodings
- Sub-module instr_counter (CNT_W-bit, sync active-low clear, enable input) holds the retire counter. The FSM stays in one module.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=000000 -> estado sequence 0,1,2,7,8,1. ALUOp=10 in EXEC, RegWrite=1 and RegDst=1 in ALUWB, instr_count=1.
- lw (100011) with mem_ready low 2 cycles in MEMRD -> estado 1,2,3,4,4,4,5,1. MemRead held high, RegWrite=1 and MemtoReg=1 in MEMWB only, instr_count +1.
- sw (101011) then beq (000100) -> MemWrite=1 only in MEMWR, ALUOp=01 and PCWriteCond=1 in BRANCH. instr_count +2; FETCH stalls with mem_ready=0 and holds IRWrite=0.
- opcode=111111 in DECODE -> illegal_op high exactly 1 cycle, next state FETCH, instr_count unchanged. Repeat with opcode=001000 and ADDI_EN=0, same result.
- rst_n=0 for one edge during a MEMWR wait -> MemWrite=0 next cycle, estado=0, instr_count=0, then FETCH.
- CNT_W=4: run 16 j (000010) instructions -> instr_count wraps from 15 to 0. PCWrite=1 with PCSource=10 in every JUMP state.
